// File: rtl/tick_report_pkg.sv
// Shared types and constants for the tick reporter: FSM states, ASCII codes, line layout, BCD helpers.
// TICK_REPORT_CRLF_EN selects a CR LF terminator (6-byte line) instead of a single space (5-byte line).
package tick_report_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, NEXT} state_t;

    localparam logic [7:0] ASC_ZERO = 8'h30;
    localparam logic [7:0] ASC_CR   = 8'h0D;
    localparam logic [7:0] ASC_LF   = 8'h0A;
    localparam logic [7:0] ASC_SP   = 8'h20;

`ifdef TICK_REPORT_CRLF_EN
    localparam int LINE_LEN = 6;
`else
    localparam int LINE_LEN = 5;
`endif
    localparam logic [2:0] LAST_IDX = 3'(LINE_LEN - 1);

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Byte ROM: four digits MSD first, then the terminator.
    function automatic logic [7:0] line_byte(input logic [15:0] snap, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = ASC_ZERO + {4'd0, snap[15:12]};
            3'd1:    b = ASC_ZERO + {4'd0, snap[11:8]};
            3'd2:    b = ASC_ZERO + {4'd0, snap[7:4]};
            3'd3:    b = ASC_ZERO + {4'd0, snap[3:0]};
`ifdef TICK_REPORT_CRLF_EN
            3'd4:    b = ASC_CR;
            3'd5:    b = ASC_LF;
`else
            3'd4:    b = ASC_SP;
`endif
            default: b = ASC_SP;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start is taken when idle or in the final stop-bit cycle, so bytes can run back to back.
// tx changes on the edge after start; done pulses during the last cycle of the stop bit.
module uart_tx_byte #(
    parameter int unsigned BAUD_DIV = 4
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);

    logic [9:0]  shreg;
    logic [3:0]  bit_cnt;
    logic [15:0] baud_cnt;
    logic        bit_end;

    assign bit_end = (baud_cnt == BIT_LAST);
    assign done    = busy && bit_end && (bit_cnt == 4'd9);
    assign tx      = shreg[0];

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            shreg    <= '1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else if (start && (!busy || done)) begin
            busy     <= 1'b1;
            shreg    <= {1'b1, data, 1'b0};
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else if (busy) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    busy <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {1'b1, shreg[9:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/tick_uart_reporter.sv
// Counts 0.25 s ticks into quarters + BCD seconds and sends each completed second as an ASCII line over 8N1 UART.
// Start bit 2 cycles after the completing tick; one-deep pending report, overrun pulse on overwrite; TICK_REPORT_CRLF_EN picks CR LF.
module tick_uart_reporter
    import tick_report_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 4
) (
    input  logic        reset,
    input  logic        clk_in,
    input  logic        tick_025s,
    input  logic        clr,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic [15:0] sec_bcd,
    output logic [1:0]  quarter,
    output logic        overrun
);

    state_t      state, state_nxt;
    logic        sec_done;
    logic [15:0] cur_snap, pend_snap;
    logic        pend;
    logic [2:0]  idx;
    logic        ser_start, ser_done, ser_busy;
    logic [7:0]  ser_data;
    logic        take_new, take_pend, step, chain;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            quarter  <= '0;
            sec_bcd  <= '0;
            sec_done <= 1'b0;
        end else begin
            sec_done <= 1'b0;
            if (clr) begin
                quarter <= '0;
                sec_bcd <= '0;
            end else if (tick_025s) begin
                quarter <= quarter + 2'd1;
                if (quarter == 2'd3) begin
                    sec_bcd  <= bcd_inc(sec_bcd);
                    sec_done <= 1'b1;
                end
            end
        end
    end

    // The next byte is handed over during the current stop bit's final cycle,
    // so NEXT only follows the serialiser rather than gating it.
    always_comb begin
        state_nxt = state;
        ser_start = 1'b0;
        ser_data  = line_byte(cur_snap, idx);
        take_new  = 1'b0;
        take_pend = 1'b0;
        step      = 1'b0;
        chain     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sec_done) begin
                    take_new  = 1'b1;
                    state_nxt = LOAD;
                end else if (pend) begin
                    take_pend = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ser_start = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (ser_done) begin
                    if (idx != LAST_IDX) begin
                        step      = 1'b1;
                        ser_start = 1'b1;
                        ser_data  = line_byte(cur_snap, idx + 3'd1);
                        state_nxt = NEXT;
                    end else if (pend) begin
                        chain     = 1'b1;
                        ser_start = 1'b1;
                        ser_data  = line_byte(pend_snap, 3'd0);
                        state_nxt = NEXT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            NEXT:    state_nxt = SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur_snap  <= '0;
            pend_snap <= '0;
            pend      <= 1'b0;
            idx       <= '0;
            overrun   <= 1'b0;
        end else begin
            state   <= state_nxt;
            overrun <= 1'b0;
            if (take_new) begin
                cur_snap <= sec_bcd;
                idx      <= '0;
            end else if (take_pend || chain) begin
                cur_snap <= pend_snap;
                idx      <= '0;
            end else if (step) begin
                idx <= idx + 3'd1;
            end
            // A line already in flight: park the newest count, flag if one was still waiting.
            if (sec_done && state != IDLE) begin
                pend_snap <= sec_bcd;
                pend      <= 1'b1;
                overrun   <= pend && !chain;
            end else if (take_new) begin
                pend    <= 1'b0;
                overrun <= pend;
            end else if (take_pend || chain) begin
                pend <= 1'b0;
            end
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_ser (
        .clk_in (clk_in),
        .reset  (reset),
        .start  (ser_start),
        .data   (ser_data),
        .tx     (uart_tx),
        .busy   (ser_busy),
        .done   (ser_done)
    );

    assign tx_busy = ser_busy;

endmodule
